mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between instruction fetch and the load/store path.
//  Decode drives mem_wEn and wb_sel; the store/load request enters through the d_* port.
//  Sits between fetch/execute and the unified memory.
//  Data wins conflicts by default; a starvation counter forces a fetch grant after a bounded wait.
// PARAMETERS
//  ADDRESS_BITS  16  width of every address port
//  DATA_WIDTH    32  width of every data port
//  STARVE_LIMIT  4   consecutive denied fetch cycles before fetch wins a conflict (>=1)
// PORTS
//  clock      in   1             single clock; everything is sampled on its rising edge
//  reset      in   1             synchronous, active-high
//  if_req     in   1             fetch read request; held until if_gnt
//  if_addr    in   ADDRESS_BITS  fetch address (PC)
//  if_gnt     out  1             fetch request accepted this cycle
//  if_rvalid  out  1             if_rdata valid (the cycle after an if_gnt)
//  if_rdata   out  DATA_WIDTH    fetched instruction
//  d_req      in   1             data request; held until d_gnt
//  d_we       in   1             1 = store, 0 = load
//  d_addr     in   ADDRESS_BITS  data address (ALU result)
//  d_wdata    in   DATA_WIDTH    store data
//  d_gnt      out  1             data request accepted this cycle
//  d_rvalid   out  1             d_rdata valid (the cycle after a load d_gnt)
//  d_rdata    out  DATA_WIDTH    load data
//  mem_en     out  1             RAM access this cycle
//  mem_we     out  1             RAM write
//  mem_addr   out  ADDRESS_BITS  RAM address
//  mem_wdata  out  DATA_WIDTH    RAM write data
//  mem_rdata  in   DATA_WIDTH    RAM read data; 1-cycle latency after mem_en & !mem_we
// BEHAVIOUR
//  - Grants are combinational from the requests and registered state. At most one grant per cycle.
//    mem_* mirrors the granted requester's fields in the same cycle.
//  - Grant rule, in priority order:
//    1. If starve_cnt == STARVE_LIMIT and if_req: fetch wins.
//    2. Otherwise, if d_req: data wins.
//    3. Otherwise, if if_req: fetch wins.
//  - Store grant: mem_we=1, no response, no rvalid.
//  - Read FSM (3 states, registered), next state chosen every cycle:
//      IDLE   no read in flight
//      RD_IF  fetch read in flight
//      RD_D   load in flight
//    - Fetch read grant -> RD_IF. Load grant -> RD_D. Store or no grant -> IDLE.
//    - The RAM is pipelined, so a new grant is legal in the RD_* states; back-to-back reads get back-to-back responses.
//  - Responses:
//    - if_rvalid = (state == RD_IF); d_rvalid = (state == RD_D).
//    - The *_rdata of the active requester = mem_rdata. The other requester's *_rdata = 0.
//  - starve_cnt, width clog2(STARVE_LIMIT+1):
//    - +1 on each cycle with if_req & !if_gnt; saturates at STARVE_LIMIT.
//    - Cleared on if_gnt, or when if_req is low.
//  - When mem_en=0: mem_we=0, mem_addr=0, mem_wdata=0.
//  - Reset values: state=IDLE, starve_cnt=0. In the reset cycle all grants, rvalids, rdata and mem_* outputs are 0.
//  - Reset mid-read: the in-flight response is dropped; no rvalid in the cycle after reset.
//  - Requests are not registered: dropping a req before its grant is legal and leaves no state.
// CONFIGURATION
//  - ARB_PERF_CNT_EN defined: adds outputs perf_if_stall[31:0] and perf_d_stall[31:0].
//    - Each counts cycles with that requester's req high and its gnt low.
//    - Both wrap at 2^32 and are cleared by reset.
//  - ARB_PERF_CNT_EN undefined: neither the ports nor the counters exist; arbitration is identical.
// STRUCTURE
//  - Package riscy_mem_pkg holds:
//    - the FSM state typedef {IDLE, RD_IF, RD_D} as a 2-bit localparam encoding
//    - requester ID constants REQ_IF / REQ_D
//    - the read latency constant MEM_RD_LAT=1
//  - One sub-module, mem_arb_starve_ctr: saturating counter with inc/clr inputs and an at_limit output.
//  - The grant mux and FSM stay in the top module.
// TESTING
//  1. Reset, then fetch only:
//     - if_req=1, if_addr=0x0004 -> if_gnt=1 same cycle, mem_addr=0x0004.
//     - Next cycle if_rvalid=1 and if_rdata=RAM[0x0004].
//  2. Conflict:
//     - if_req=1 and d_req=1, d_we=0, d_addr=0x0100 -> d_gnt=1, if_gnt=0.
//     - Next cycle d_rvalid=1, d_rdata=RAM[0x0100], if_rvalid=0.
//  3. Store:
//     - d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xDEADBEEF -> mem_we=1, no rvalid next cycle.
//     - A following load of 0x0040 returns 0xDEADBEEF.
//  4. Starvation, with d_req and if_req held high and STARVE_LIMIT=4:
//     - d_gnt for 4 cycles, then if_gnt on the 5th; starve_cnt returns to 0.
//  5. Back-to-back reads:
//     - Alternate load and fetch grants -> alternating d_rvalid/if_rvalid on consecutive cycles, each with the correct data.
//  6. Reset mid-read:
//     - Assert reset in the cycle after a load grant -> d_rvalid=0, state=IDLE.
//     - With ARB_PERF_CNT_EN defined, both perf counters read 0.

Source files
------------

// File: rtl/riscy_mem_pkg.sv
// riscy_mem_pkg: shared types and constants for the unified-memory port arbiter.
package riscy_mem_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_IF = 2'd1,
      RD_D  = 2'd2
   } rd_state_t;
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D = 1'b1;
   localparam int MEM_RD_LAT = 1;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of consecutive denied fetch cycles.
module mem_arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   assign at_limit = cnt == W'(LIMIT);
   always_ff @(posedge clock) begin
      if (reset || clr) cnt <= '0;
      else if (inc && !at_limit) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined single-port RAM between fetch and load/store.
// ARB_PERF_CNT_EN adds per-requester stall counters.
module mem_port_arbiter
   import riscy_mem_pkg::*;
#(
   parameter int ADDRESS_BITS = 16,
   parameter int DATA_WIDTH = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDRESS_BITS-1:0] if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDRESS_BITS-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]             perf_if_stall,
   output logic [31:0]             perf_d_stall
`endif
);
   rd_state_t state;
   logic at_limit;
   logic sel;
   mem_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clock(clock),
      .reset(reset),
      .inc(if_req && !if_gnt),
      .clr(if_gnt || !if_req),
      .at_limit(at_limit)
   );
   // Data wins unless fetch has waited STARVE_LIMIT cycles in a row.
   always_comb begin
      if_gnt = !reset && if_req && (at_limit || !d_req);
      d_gnt = !reset && d_req && !if_gnt;
      sel = if_gnt ? REQ_IF : REQ_D;
      mem_en = if_gnt || d_gnt;
      mem_we = d_gnt && d_we;
      mem_addr = !mem_en ? '0 : (sel == REQ_IF) ? if_addr : d_addr;
      mem_wdata = mem_we ? d_wdata : '0;
      if_rvalid = !reset && state == RD_IF;
      d_rvalid = !reset && state == RD_D;
      if_rdata = if_rvalid ? mem_rdata : '0;
      d_rdata = d_rvalid ? mem_rdata : '0;
   end
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= if_gnt ? RD_IF : (d_gnt && !d_we) ? RD_D : IDLE;
   end
`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_if_stall <= '0;
         perf_d_stall <= '0;
      end else begin
         if (if_req && !if_gnt) perf_if_stall <= perf_if_stall + 32'd1;
         if (d_req && !d_gnt) perf_d_stall <= perf_d_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural RAM and a reference grant model.
module tb_mem_port_arbiter;
   localparam int LIM = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0, mem_addr;
   logic [31:0] d_wdata = '0, mem_wdata, if_rdata, d_rdata;
   logic [31:0] mem_rdata = '0;
   logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_stall, perf_d_stall;
   int p_if = 0, p_d = 0;
`endif
   int n_tests = 0, n_fail = 0;
   int scnt = 0;
   logic pend_i = 1'b0, pend_d = 1'b0;
   logic [31:0] q_i[$], q_d[$];
   logic [31:0] ram[logic [15:0]];
   logic [31:0] ref_wr[logic [15:0]];

   mem_port_arbiter dut (
      .clock(clk), .reset(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
   );

   function automatic logic [31:0] init_val(input logic [15:0] a);
      return {~a, a} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ref_val(input logic [15:0] a);
      return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic ir, input logic [15:0] ia,
                      input logic dr, input logic dw, input logic [15:0] da, input logic [31:0] wd);
      logic egi, egd;
      logic [31:0] ei, ed;
      @(negedge clk);
      rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
      #2;
      egi = !r && ir && (scnt == LIM || !dr);
      egd = !r && dr && !egi;
      chk("if_gnt", if_gnt, egi);
      chk("d_gnt", d_gnt, egd);
      chk("mem_en", mem_en, egi || egd);
      chk("mem_we", mem_we, egd && dw);
      chk("mem_addr", {16'h0, mem_addr}, egi ? {16'h0, ia} : egd ? {16'h0, da} : 32'h0);
      chk("mem_wdata", mem_wdata, (egd && dw) ? wd : 32'h0);
      chk("if_rvalid", if_rvalid, pend_i && !r);
      chk("d_rvalid", d_rvalid, pend_d && !r);
      ei = (pend_i && q_i.size() > 0) ? q_i.pop_front() : 32'h0;
      ed = (pend_d && q_d.size() > 0) ? q_d.pop_front() : 32'h0;
      chk("if_rdata", if_rdata, r ? 32'h0 : ei);
      chk("d_rdata", d_rdata, r ? 32'h0 : ed);
`ifdef ARB_PERF_CNT_EN
      if (!r) begin
         chk("perf_if_stall", perf_if_stall, p_if);
         chk("perf_d_stall", perf_d_stall, p_d);
      end
      p_if = r ? 0 : p_if + int'(ir && !egi);
      p_d = r ? 0 : p_d + int'(dr && !egd);
`endif
      pend_i = egi;
      pend_d = egd && !dw;
      if (egi) q_i.push_back(ref_val(ia));
      if (egd && !dw) q_d.push_back(ref_val(da));
      if (egd && dw) ref_wr[da] = wd;
      scnt = (r || !ir || egi) ? 0 : (scnt < LIM ? scnt + 1 : scnt);
   endtask

   initial begin
      cyc(1, 0, 16'h0, 0, 0, 16'h0, 0);
      cyc(1, 1, 16'h0004, 1, 1, 16'h0100, 32'h1234_5678);
      // fetch only
      cyc(0, 1, 16'h0004, 0, 0, 16'h0, 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      // conflict: data wins, fetch stays pending
      cyc(0, 1, 16'h0004, 1, 0, 16'h0100, 0);
      cyc(0, 1, 16'h0004, 0, 0, 16'h0, 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      // store then load back
      cyc(0, 0, 16'h0, 1, 1, 16'h0040, 32'hDEAD_BEEF);
      cyc(0, 0, 16'h0, 1, 0, 16'h0040, 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      // starvation with both requests held
      for (int k = 0; k < 7; k++) cyc(0, 1, 16'h0008, 1, 0, 16'h0200 + 16'(k), 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      // alternating back-to-back reads
      for (int k = 0; k < 8; k++)
         cyc(0, k % 2 == 1, 16'h0010 + 16'(k), k % 2 == 0, 0, 16'h0300 + 16'(k), 0);
      for (int k = 0; k < 60; k++)
         cyc(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      // reset the cycle after a load grant
      cyc(0, 0, 16'h0, 1, 0, 16'h0040, 0);
      cyc(1, 1, 16'h0004, 1, 0, 16'h0100, 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      cyc(0, 1, 16'h0020, 0, 0, 16'h0, 0);
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
